volley_sequencer: RTL

Front-end stage that feeds one `layer`. It accepts one input sample (per-pixel intensities plus a train/infer flag) over a valid/ready handshake and encodes every intensity into a time-to-first-spike value. It then drives the layer's `time_val`, `spike_times` and `training` through one full sample period. Each period ends by capturing the layer's `winning_neuron` / `output_spike_time` and presenting them on a result valid/ready handshake.

---
 rtl/volley_sequencer_pkg.sv | 28 ++
 rtl/volley_sequencer_intensity_encoder.sv | 27 ++
 rtl/volley_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/volley_sequencer_pkg.sv
// Shared widths, state encoding and spike types for the volley sequencer and its
// intensity encoders.
package volley_sequencer_pkg;

    localparam int unsigned log_testing_period    = 4;
    localparam int unsigned testing_period        = 16;
    localparam int unsigned log_time_period       = 4;
    localparam int unsigned time_period           = 20;
    localparam int unsigned num_spikes            = 5;
    localparam int unsigned log_neurons_per_layer = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [log_testing_period:0]    spike_t;
    typedef logic [log_time_period:0]       time_t;
    typedef logic [log_neurons_per_layer:0] neuron_t;

    localparam spike_t  NO_SPIKE  = '1;
    localparam neuron_t NO_NEURON = '1;

    // Training runs the full period; its end value doubles as the idle value.
    localparam time_t TRAIN_END = time_t'(time_period - 1);
    localparam time_t TEST_END  = time_t'(testing_period - 1);

endpackage

// File: rtl/volley_sequencer_intensity_encoder.sv
// Time-to-first-spike encoder for one pixel: brighter pixels spike earlier,
// dim pixels and late spikes beyond the testing window produce NO_SPIKE.
module intensity_encoder
    import volley_sequencer_pkg::*;
#(
    parameter int unsigned PIX_BITS      = 8,
    parameter int unsigned MIN_INTENSITY = 16
) (
    input  logic [PIX_BITS-1:0] pixel_i,
    output spike_t              spike_o
);

    localparam int unsigned SHIFT = PIX_BITS - log_testing_period;

    logic [PIX_BITS-1:0] t;

    // ~p equals (2^PIX_BITS-1) - p for an unsigned pixel.
    assign t = (~pixel_i) >> SHIFT;

    always_comb begin
        spike_o = NO_SPIKE;
        if ((32'(pixel_i) >= MIN_INTENSITY) && (32'(t) < testing_period)) begin
            spike_o = {1'b0, t[log_testing_period-1:0]};
        end
    end

endmodule

// File: rtl/volley_sequencer.sv
// Sample front-end for one layer: accepts a sample, encodes spike times, sweeps
// time_val through one period and hands back the layer's winner on a result handshake.
module volley_sequencer
    import volley_sequencer_pkg::*;
#(
    parameter int unsigned PIX_BITS      = 8,
    parameter int unsigned MIN_INTENSITY = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [num_spikes-1:0][PIX_BITS-1:0] in_pixels,
    input  logic                                in_train,
    output time_t                               time_val,
    output spike_t [num_spikes-1:0]             spike_times,
    output logic                                training,
    input  neuron_t                             layer_winning_neuron,
    input  spike_t                              layer_output_spike_time,
    output logic                                sample_done,
    output logic                                result_valid,
    input  logic                                result_ready,
    output neuron_t                             result_neuron,
    output spike_t                              result_time
);

    state_e                  state_q;
    time_t                   time_val_q;
    time_t                   time_val_d;
    time_t                   run_end;
    spike_t [num_spikes-1:0] spike_times_q;
    spike_t [num_spikes-1:0] enc_spikes;
    logic                    training_q;
    logic                    sample_done_q;
    logic                    result_valid_q;
    neuron_t                 result_neuron_q;
    spike_t                  result_time_q;
    logic                    accept;

    for (genvar i = 0; i < int'(num_spikes); i++) begin : g_enc
        intensity_encoder #(
            .PIX_BITS      (PIX_BITS),
            .MIN_INTENSITY (MIN_INTENSITY)
        ) u_enc (
            .pixel_i (in_pixels[i]),
            .spike_o (enc_spikes[i])
        );
    end

    // A pending result blocks new samples so it can never be overwritten.
    assign in_ready   = (state_q == IDLE) && !result_valid_q;
    assign accept     = in_valid && in_ready;
    assign run_end    = training_q ? TRAIN_END : TEST_END;
    assign time_val_d = time_val_q + time_t'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            time_val_q      <= TRAIN_END;
            spike_times_q   <= {num_spikes{NO_SPIKE}};
            training_q      <= 1'b0;
            sample_done_q   <= 1'b0;
            result_valid_q  <= 1'b0;
            result_neuron_q <= NO_NEURON;
            result_time_q   <= NO_SPIKE;
        end else begin
            sample_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q       <= RUN;
                        time_val_q    <= '0;
                        spike_times_q <= enc_spikes;
                        training_q    <= in_train;
                    end
                end
                RUN: begin
                    if (time_val_q == run_end) begin
                        state_q    <= IDLE;
                        time_val_q <= TRAIN_END;
                    end else begin
                        time_val_q    <= time_val_d;
                        sample_done_q <= (time_val_d == run_end);
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The layer's decision is final once the testing window has elapsed.
            if ((state_q == RUN) && (time_val_q == TEST_END)) begin
                result_valid_q  <= 1'b1;
                result_neuron_q <= layer_winning_neuron;
                result_time_q   <= layer_output_spike_time;
            end else if (result_valid_q && result_ready) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign time_val      = time_val_q;
    assign spike_times   = spike_times_q;
    assign training      = training_q;
    assign sample_done   = sample_done_q;
    assign result_valid  = result_valid_q;
    assign result_neuron = result_neuron_q;
    assign result_time   = result_time_q;

endmodule
